// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller: cause codes,
// mem_exc flag positions, the exception record payload and FSM encoding.
package exc_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned EXC_FLAGS_W = 8;
  localparam int unsigned EXC_CODE_W  = 5;
  localparam int unsigned HW_IRQ_W    = 6;

  localparam logic [DATA_W-1:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // mem_exc bit positions
  localparam int unsigned EXC_ADEL_IF = 0;
  localparam int unsigned EXC_RI      = 1;
  localparam int unsigned EXC_OV      = 2;
  localparam int unsigned EXC_SYS     = 3;
  localparam int unsigned EXC_BP      = 4;
  localparam int unsigned EXC_ADEL_LD = 5;
  localparam int unsigned EXC_ADES    = 6;
  localparam int unsigned EXC_ERET    = 7;

  // Cause.ExcCode values
  localparam logic [EXC_CODE_W-1:0] CODE_INT  = 5'h00;
  localparam logic [EXC_CODE_W-1:0] CODE_ADEL = 5'h04;
  localparam logic [EXC_CODE_W-1:0] CODE_ADES = 5'h05;
  localparam logic [EXC_CODE_W-1:0] CODE_SYS  = 5'h08;
  localparam logic [EXC_CODE_W-1:0] CODE_BP   = 5'h09;
  localparam logic [EXC_CODE_W-1:0] CODE_RI   = 5'h0A;
  localparam logic [EXC_CODE_W-1:0] CODE_OV   = 5'h0C;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_t;

  typedef struct packed {
    logic                  flush;
    logic                  redirect_valid;
    logic [DATA_W-1:0]     redirect_pc;
    logic                  exc_we;
    logic [EXC_CODE_W-1:0] exc_code;
    logic [DATA_W-1:0]     epc;
    logic                  bd;
    logic                  badvaddr_we;
    logic [DATA_W-1:0]     badvaddr;
    logic                  eret;
  } exc_rec_t;

endpackage

// File: rtl/exc_ctrl_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle and raises
// timer_irq on a Count==Compare match until Compare is rewritten.
module cp0_timer
  import exc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic              timer_irq
);

  logic [DATA_W-1:0] compare_q;
  logic              toggle_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      // A software write of Count wins over the half-rate increment
      if (count_we) begin
        count    <= wdata;
        toggle_q <= 1'b0;
      end else begin
        toggle_q <= ~toggle_q;
        if (toggle_q) count <= count + 32'd1;
      end
      if (compare_we) compare_q <= wdata;
      if (compare_we)              timer_irq <= 1'b0;
      else if (count == compare_q) timer_irq <= 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller with registered flush/redirect and
// CP0 record outputs. Define EXC_CTRL_TIMER_EN to include the Count/Compare timer.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
  parameter int unsigned       TIMER_IRQ_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  input  logic [EXC_FLAGS_W-1:0] mem_exc,
  input  logic [DATA_W-1:0]      mem_pc,
  input  logic                   mem_in_delay_slot,
  input  logic [DATA_W-1:0]      mem_badvaddr,
  input  logic [DATA_W-1:0]      cp0_status,
  input  logic [DATA_W-1:0]      cp0_cause,
  input  logic [DATA_W-1:0]      cp0_epc,
  input  logic [HW_IRQ_W-1:0]    int_in,
  input  logic                   cp0_count_we,
  input  logic                   cp0_compare_we,
  input  logic [DATA_W-1:0]      cp0_wdata,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [DATA_W-1:0]      redirect_pc,
  output logic                   cp0_exc_we,
  output logic [EXC_CODE_W-1:0]  cp0_exc_code,
  output logic [DATA_W-1:0]      cp0_epc_out,
  output logic                   cp0_bd,
  output logic                   cp0_badvaddr_we,
  output logic [DATA_W-1:0]      cp0_badvaddr,
  output logic                   cp0_eret,
  output logic [HW_IRQ_W-1:0]    cp0_ip_hw,
  output logic [DATA_W-1:0]      count_out
);

  exc_state_t          state_q, state_d;
  exc_rec_t            rec_q, rec_d;
  logic [HW_IRQ_W-1:0] ip_sync1_q, ip_sync2_q;
  logic                timer_irq;
  logic [7:0]          int_pending;
  logic                int_taken;
  logic [DATA_W-1:0]   epc_val;
  logic                unused_cp0_bits;

`ifdef EXC_CTRL_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (cp0_count_we),
    .compare_we (cp0_compare_we),
    .wdata      (cp0_wdata),
    .count      (count_out),
    .timer_irq  (timer_irq)
  );
`else
  logic unused_timer_in;
  assign count_out       = '0;
  assign timer_irq       = 1'b0;
  assign unused_timer_in = ^{cp0_count_we, cp0_compare_we, cp0_wdata};
`endif

  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                             cp0_cause[31:10], cp0_cause[7:0]};

  // Pending IP[7:0] masked by Status.IM; gated by IE and EXL
  assign cp0_ip_hw   = ip_sync2_q | (HW_IRQ_W'(timer_irq) << TIMER_IRQ_BIT);
  assign int_pending = {cp0_ip_hw, cp0_cause[9:8]} & cp0_status[15:8];
  assign int_taken   = mem_valid & cp0_status[0] & ~cp0_status[1] & (|int_pending);
  assign epc_val     = mem_in_delay_slot ? (mem_pc - 32'd4) : mem_pc;

  // State, synchronizer and exception record registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      ip_sync1_q <= '0;
      ip_sync2_q <= '0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      ip_sync1_q <= int_in;
      ip_sync2_q <= ip_sync1_q;
    end
  end

  // Next state and next exception record; the killed instruction is ignored in FLUSH
  always_comb begin
    state_d = state_q;
    rec_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && (int_taken || (|mem_exc))) begin
          state_d              = ST_FLUSH;
          rec_d.flush          = 1'b1;
          rec_d.redirect_valid = 1'b1;
          rec_d.redirect_pc    = EXC_VECTOR;
          rec_d.exc_we         = 1'b1;
          rec_d.epc            = epc_val;
          rec_d.bd             = mem_in_delay_slot;
          if (int_taken) begin
            rec_d.exc_code = CODE_INT;
          end else if (mem_exc[EXC_ADEL_IF]) begin
            rec_d.exc_code    = CODE_ADEL;
            rec_d.badvaddr_we = 1'b1;
            rec_d.badvaddr    = mem_pc;
          end else if (mem_exc[EXC_RI]) begin
            rec_d.exc_code = CODE_RI;
          end else if (mem_exc[EXC_OV]) begin
            rec_d.exc_code = CODE_OV;
          end else if (mem_exc[EXC_SYS]) begin
            rec_d.exc_code = CODE_SYS;
          end else if (mem_exc[EXC_BP]) begin
            rec_d.exc_code = CODE_BP;
          end else if (mem_exc[EXC_ADEL_LD]) begin
            rec_d.exc_code    = CODE_ADEL;
            rec_d.badvaddr_we = 1'b1;
            rec_d.badvaddr    = mem_badvaddr;
          end else if (mem_exc[EXC_ADES]) begin
            rec_d.exc_code    = CODE_ADES;
            rec_d.badvaddr_we = 1'b1;
            rec_d.badvaddr    = mem_badvaddr;
          end else if (mem_exc[EXC_ERET]) begin
            rec_d.exc_we      = 1'b0;
            rec_d.epc         = '0;
            rec_d.bd          = 1'b0;
            rec_d.eret        = 1'b1;
            rec_d.redirect_pc = cp0_epc;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign flush           = rec_q.flush;
  assign redirect_valid  = rec_q.redirect_valid;
  assign redirect_pc     = rec_q.redirect_pc;
  assign cp0_exc_we      = rec_q.exc_we;
  assign cp0_exc_code    = rec_q.exc_code;
  assign cp0_epc_out     = rec_q.epc;
  assign cp0_bd          = rec_q.bd;
  assign cp0_badvaddr_we = rec_q.badvaddr_we;
  assign cp0_badvaddr    = rec_q.badvaddr;
  assign cp0_eret        = rec_q.eret;

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, general exception entry PC.
REQ-002 Parameter TIMER_IRQ_BIT, default 5, int_in index ORed with the timer interrupt.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 mem_valid  in  1  MEM-stage instruction commits this cycle.
REQ-006 mem_exc  in  8  flags: [0]AdEL-fetch [1]RI [2]Ov [3]Syscall [4]Break [5]AdEL-load [6]AdES [7]ERET.
REQ-007 mem_pc  in  32  PC of MEM instruction.
REQ-008 mem_in_delay_slot  in  1  MEM instruction is in a branch delay slot.
REQ-009 mem_badvaddr  in  32  faulting data address (load/store).
REQ-010 cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 register values.
REQ-011 int_in  in  6  asynchronous hardware interrupt lines.
REQ-012 cp0_count_we, cp0_compare_we  in  1 each; cp0_wdata  in  32  CP0 Count/Compare writes.
REQ-013 flush  out  1  kill all pipeline stages up to and including MEM.
REQ-014 redirect_valid  out  1; redirect_pc  out  32  fetch target.
REQ-015 cp0_exc_we  out  1; cp0_exc_code  out  5; cp0_epc_out  out  32; cp0_bd  out  1  exception record for CP0.
REQ-016 cp0_badvaddr_we  out  1; cp0_badvaddr  out  32.
REQ-017 cp0_eret  out  1  clear Status.EXL.
REQ-018 cp0_ip_hw  out  6  synchronized pending hardware interrupts (Cause.IP[7:2]).
REQ-019 count_out  out  32  Count register value.

Function
REQ-020 int_in SHALL pass through a 2-flop synchronizer before use; cp0_ip_hw is the second flop (bit TIMER_IRQ_BIT ORed with timer_irq).
REQ-021 Interrupt taken SHALL = mem_valid & Status.IE & !Status.EXL & |({cp0_ip_hw, Cause.IP[1:0]} & Status.IM[7:0]).
REQ-022 Priority SHALL be Int(0x00) > AdEL-fetch(0x04) > RI(0x0A) > Ov(0x0C) > Syscall(0x08) > Break(0x09) > AdEL-load(0x04) > AdES(0x05) > ERET.
REQ-023 FSM states IDLE, FLUSH; IDLE->FLUSH on mem_valid with any interrupt, exception or ERET; FLUSH->IDLE unconditionally after one cycle.
REQ-024 All exception outputs SHALL be registered: event in MEM at cycle N -> flush, redirect_valid, cp0_exc_we/cp0_eret/cp0_badvaddr_we high exactly for cycle N+1 (state FLUSH).
REQ-025 In FLUSH, mem_valid and mem_exc SHALL be ignored (instruction already killed).
REQ-026 Exception: redirect_pc=EXC_VECTOR; cp0_epc_out=mem_pc-4 and cp0_bd=1 if mem_in_delay_slot, else mem_pc and 0.
REQ-027 AdEL-fetch: cp0_badvaddr=mem_pc; AdEL-load/AdES: cp0_badvaddr=mem_badvaddr; cp0_badvaddr_we only for these three.
REQ-028 ERET (no higher-priority event): redirect_pc=cp0_epc, cp0_eret=1, cp0_exc_we=0.
REQ-029 Simultaneous exception flags SHALL record only the highest-priority one; one event per instruction.

Reset
REQ-030 rst low at posedge clk: state IDLE, all outputs 0, synchronizer flops 0, Count 0, Compare 0, timer_irq 0; an in-progress FLUSH is abandoned.

Configuration
REQ-031 Macro EXC_CTRL_TIMER_EN defined: Count increments every second cycle (toggle flop), wraps 32'hFFFFFFFF->0; cp0_count_we loads Count (toggle cleared); timer_irq set when Count==Compare, held until cp0_compare_we; write of Count on match cycle takes priority over increment.
REQ-032 Macro undefined: no Count/Compare logic; count_out=0; timer_irq=0; write inputs ignored.

Structure
REQ-033 Exception-code constants, mem_exc bit indices and EXC_VECTOR default SHALL live in the shared bus/define package.
REQ-034 Timer SHALL be a sub-module cp0_timer (instantiated only under EXC_CTRL_TIMER_EN).

Verification
REQ-035 mem_valid=1, mem_exc=8'h04, mem_pc=32'h80001000, not delay slot -> next cycle flush=1, code 0x0C, epc 80001000, bd=0, redirect BFC00380.
REQ-036 mem_exc=8'h21, mem_in_delay_slot=1, mem_pc=32'h80000008 -> code 0x04, epc 80000004, bd=1, badvaddr 80000008.
REQ-037 int_in[2]=1, Status IE=1/EXL=0/IM[4]=1, mem_exc=8'h08 -> code 0x00 taken 3 cycles after int_in rises (sync), Syscall suppressed.
REQ-038 mem_exc=8'h80, cp0_epc=32'h80002000 -> cp0_eret=1, redirect 80002000, cp0_exc_we=0; exception in following cycle ignored.
REQ-039 Timer on: write Compare=10, Count=0 -> cp0_ip_hw[5]=1 after 20 cycles, cleared the cycle after cp0_compare_we.
REQ-040 rst low during FLUSH -> all outputs 0 next cycle, state IDLE.
